// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and DRAM request constants for the DMA engine
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SRD,
    SCAP,
    DREQ,
    DWAIT,
    SWR,
    NEXT,
    DONE
  } dma_state_e;

  localparam logic       DIR_D2S      = 1'b0;
  localparam logic       DIR_S2D      = 1'b1;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic       DRAM_W_READ  = 1'b1;
  localparam logic       DRAM_W_WRITE = 1'b0;

endpackage

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - DRAM/SRAM address walkers and remaining-word counter for the DMA engine
module dma_addr_gen #(
  parameter int ADDR_W      = 32,
  parameter int SRAM_AW     = 12,
  parameter int MAX_WORDS_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  cfg_start_i,
  input  logic [ADDR_W-1:0]  cfg_end_i,
  input  logic [SRAM_AW-1:0] cfg_sram_base_i,
  input  logic               load_i,
  input  logic               step_i,
  output logic [ADDR_W-1:0]  dram_addr_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic               range_err_o,
  output logic               last_o
);

  logic [ADDR_W-3:0]      start_w, end_w, span;
  logic [ADDR_W-1:0]      dram_addr_q;
  logic [SRAM_AW-1:0]     sram_addr_q;
  logic [MAX_WORDS_W-1:0] remaining_q;
  logic                   unused_bits;

  assign start_w     = cfg_start_i[ADDR_W-1:2];
  assign end_w       = cfg_end_i[ADDR_W-1:2];
  assign span        = end_w - start_w;
  assign range_err_o = end_w < start_w;
  assign last_o      = remaining_q == MAX_WORDS_W'(1);
  assign dram_addr_o = dram_addr_q;
  assign sram_addr_o = sram_addr_q;
  assign unused_bits = ^{cfg_start_i[1:0], cfg_end_i[1:0], span[ADDR_W-3:MAX_WORDS_W]};

  // Both address walkers wrap silently at their natural widths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dram_addr_q <= '0;
      sram_addr_q <= '0;
      remaining_q <= '0;
    end else if (load_i) begin
      dram_addr_q <= {start_w, 2'b00};
      sram_addr_q <= cfg_sram_base_i;
      remaining_q <= span[MAX_WORDS_W-1:0] + MAX_WORDS_W'(1);
    end else if (step_i) begin
      dram_addr_q <= dram_addr_q + ADDR_W'(4);
      sram_addr_q <= sram_addr_q + SRAM_AW'(1);
      remaining_q <= remaining_q - MAX_WORDS_W'(1);
    end
  end

endmodule

// File: rtl/dma_dram_engine.sv
// rtl/dma_dram_engine.sv - single-outstanding-word DMA between DRAM wrapper and local SRAM
// Optional DRAM ack timeout built when DMA_TIMEOUT_EN is defined.
module dma_dram_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int SRAM_AW     = 12,
  parameter int MAX_WORDS_W = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  cfg_start,
  input  logic [ADDR_W-1:0]  cfg_end,
  input  logic [SRAM_AW-1:0] cfg_sram_base,
  input  logic               cfg_dir,
  input  logic               cfg_go,
  input  logic               irq_clr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               dram_access,
  output logic               dram_w,
  output logic [1:0]         dram_size,
  output logic [ADDR_W-1:0]  dram_addr,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic               dram_data_ready,
  input  logic               dram_store_done,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  dma_state_e  state_q;
  logic        busy_q, done_q, err_q, dir_q;
  logic        dram_access_q, dram_w_q, sram_cs_q, sram_we_q;
  logic [31:0] dram_wdata_q, sram_wdata_q;
  logic        load, step, range_err, last;

  assign load = (state_q == IDLE) && cfg_go;
  assign step = (state_q == NEXT);

  dma_addr_gen #(
    .ADDR_W      (ADDR_W),
    .SRAM_AW     (SRAM_AW),
    .MAX_WORDS_W (MAX_WORDS_W)
  ) u_addr_gen (
    .clk             (clk),
    .rst             (rst),
    .cfg_start_i     (cfg_start),
    .cfg_end_i       (cfg_end),
    .cfg_sram_base_i (cfg_sram_base),
    .load_i          (load),
    .step_i          (step),
    .dram_addr_o     (dram_addr),
    .sram_addr_o     (sram_addr),
    .range_err_o     (range_err),
    .last_o          (last)
  );

`ifdef DMA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign dram_access = dram_access_q;
  assign dram_w      = dram_w_q;
  assign dram_size   = SIZE_WORD;
  assign dram_wdata  = dram_wdata_q;
  assign sram_cs     = sram_cs_q;
  assign sram_we     = sram_we_q;
  assign sram_wdata  = sram_wdata_q;

  // Outputs are registered: each branch sets the strobes that belong to the state it enters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      dir_q         <= DIR_D2S;
      dram_access_q <= 1'b0;
      dram_w_q      <= DRAM_W_READ;
      dram_wdata_q  <= '0;
      sram_cs_q     <= 1'b0;
      sram_we_q     <= 1'b0;
      sram_wdata_q  <= '0;
`ifdef DMA_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      dram_access_q <= 1'b0;
      sram_cs_q     <= 1'b0;
      sram_we_q     <= 1'b0;
      if (irq_clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (cfg_go) begin
            if (range_err) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              busy_q   <= 1'b1;
              dir_q    <= cfg_dir;
              dram_w_q <= (cfg_dir == DIR_S2D) ? DRAM_W_WRITE : DRAM_W_READ;
              if (cfg_dir == DIR_S2D) begin
                state_q   <= SRD;
                sram_cs_q <= 1'b1;
              end else begin
                state_q       <= DREQ;
                dram_access_q <= 1'b1;
              end
            end
          end
        end
        SRD: state_q <= SCAP;
        SCAP: begin
          dram_wdata_q  <= sram_rdata;
          dram_access_q <= 1'b1;
          state_q       <= DREQ;
        end
        DREQ: begin
          state_q <= DWAIT;
`ifdef DMA_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
        end
        DWAIT: begin
          if (dir_q == DIR_D2S && dram_data_ready) begin
            sram_wdata_q <= dram_rdata;
            sram_cs_q    <= 1'b1;
            sram_we_q    <= 1'b1;
            state_q      <= SWR;
          end else if (dir_q == DIR_S2D && dram_store_done) begin
            state_q <= NEXT;
          end
`ifdef DMA_TIMEOUT_EN
          else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        SWR: state_q <= NEXT;
        NEXT: begin
          if (last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else if (dir_q == DIR_S2D) begin
            sram_cs_q <= 1'b1;
            state_q   <= SRD;
          end else begin
            dram_access_q <= 1'b1;
            state_q       <= DREQ;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_dram_engine.sv
// tb/tb_dma_dram_engine.sv - scoreboard bench for dma_dram_engine with DRAM and SRAM models
module tb_dma_dram_engine;

`ifdef DMA_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 64;
`endif
  localparam int LAT = 3;

  logic        clk, rst;
  logic [31:0] cfg_start, cfg_end;
  logic [11:0] cfg_sram_base;
  logic        cfg_dir, cfg_go, irq_clr;
  logic        busy, done, err, dram_access, dram_w;
  logic [1:0]  dram_size;
  logic [31:0] dram_addr, dram_wdata, dram_rdata;
  logic        dram_data_ready, dram_store_done;
  logic        sram_cs, sram_we;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  logic        model_en, model_rdy, model_sd, spur_rdy, spur_sd;
  logic [31:0] model_rdata, spur_rdata;
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  assign dram_data_ready = model_rdy | spur_rdy;
  assign dram_store_done = model_sd | spur_sd;
  assign dram_rdata      = spur_rdy ? spur_rdata : model_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] addr; logic w; logic [31:0] wd; logic chk; } dram_exp_t;
  typedef struct { logic [11:0] addr; logic [31:0] data; } sram_exp_t;
  dram_exp_t exp_dram[$];
  sram_exp_t exp_sram[$];
  logic      exp_done[$];

  logic [31:0] dram_mem [logic [31:0]];
  logic [31:0] sram_mem [0:4095];

  dma_dram_engine #(.ADDR_W(32), .SRAM_AW(12), .MAX_WORDS_W(16), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_end(cfg_end),
    .cfg_sram_base(cfg_sram_base), .cfg_dir(cfg_dir), .cfg_go(cfg_go), .irq_clr(irq_clr),
    .busy(busy), .done(done), .err(err), .dram_access(dram_access), .dram_w(dram_w),
    .dram_size(dram_size), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata), .dram_data_ready(dram_data_ready),
    .dram_store_done(dram_store_done), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // SRAM model: 1-cycle read latency, plus a preload port for the bench.
  always @(posedge clk) begin
    if (pre_we) sram_mem[pre_addr] <= pre_data;
    if (sram_cs && !sram_we) sram_rdata <= sram_mem[sram_addr];
    if (sram_cs && sram_we) sram_mem[sram_addr] <= sram_wdata;
  end

  // DRAM model: acks LAT cycles after each request while enabled.
  initial begin
    logic [31:0] a, wd;
    logic        w;
    model_rdy = 0; model_sd = 0; model_rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (dram_access && model_en) begin
        a = dram_addr; w = dram_w; wd = dram_wdata;
        repeat (LAT) @(posedge clk);
        #1;
        if (w) begin
          model_rdata = dram_mem.exists(a) ? dram_mem[a] : 32'hBAD0_BAD0;
          model_rdy   = 1;
        end else begin
          dram_mem[a] = wd;
          model_sd    = 1;
        end
        @(posedge clk); #1;
        model_rdy = 0; model_sd = 0;
      end
    end
  end

  // Monitor: every DUT request, SRAM write and completion is matched against the scoreboard.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    dram_exp_t de;
    sram_exp_t se;
    logic      ee;
    if (dram_access) begin
      if (exp_dram.size() == 0) check("unexpected_dram_access", dram_addr, 32'hFFFF_FFFF);
      else begin
        de = exp_dram.pop_front();
        check("dram_addr", dram_addr, de.addr);
        check("dram_w", {31'd0, dram_w}, {31'd0, de.w});
        check("dram_size", {30'd0, dram_size}, 32'd2);
        if (de.chk) check("dram_wdata", dram_wdata, de.wd);
      end
    end
    if (sram_cs && sram_we) begin
      if (exp_sram.size() == 0) check("unexpected_sram_write", {20'd0, sram_addr}, 32'hFFFF_FFFF);
      else begin
        se = exp_sram.pop_front();
        check("sram_waddr", {20'd0, sram_addr}, {20'd0, se.addr});
        check("sram_wdata", sram_wdata, se.data);
      end
    end
    if (done && !done_prev) begin
      if (exp_done.size() == 0) check("unexpected_done", {31'd0, err}, 32'hFFFF_FFFF);
      else begin
        ee = exp_done.pop_front();
        check("done_err", {31'd0, err}, {31'd0, ee});
      end
    end
    done_prev <= done;
  end

  task automatic go(input logic [31:0] s, input logic [31:0] e, input logic [11:0] b, input logic d);
    @(posedge clk); #1;
    cfg_start = s; cfg_end = e; cfg_sram_base = b; cfg_dir = d; cfg_go = 1;
    @(posedge clk); #1;
    cfg_go = 0;
    cfg_start = 32'hFFFF_FFF0; cfg_end = 0; cfg_sram_base = 12'h5A5; cfg_dir = ~d;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (!done && i < budget) begin @(negedge clk); i++; end
    check({name, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_access(input int budget);
    int i = 0;
    while (!dram_access && i < budget) begin @(negedge clk); i++; end
    check("wait_access", {31'd0, dram_access}, 32'd1);
  endtask

  task automatic clear_irq();
    @(posedge clk); #1 irq_clr = 1;
    @(posedge clk); #1 irq_clr = 0;
    check("irq_clr_done", {31'd0, done}, 32'd0);
    check("irq_clr_err", {31'd0, err}, 32'd0);
  endtask

  task automatic drain_check(input string name);
    repeat (3) @(negedge clk);
    check({name, "_dram_q"}, exp_dram.size(), 0);
    check({name, "_sram_q"}, exp_sram.size(), 0);
    check({name, "_done_q"}, exp_done.size(), 0);
  endtask

  task automatic reset_outputs(input string name);
    check({name, "_busy"}, {31'd0, busy}, 0);
    check({name, "_done"}, {31'd0, done}, 0);
    check({name, "_err"}, {31'd0, err}, 0);
    check({name, "_access"}, {31'd0, dram_access}, 0);
    check({name, "_dram_w"}, {31'd0, dram_w}, 1);
    check({name, "_size"}, {30'd0, dram_size}, 2);
    check({name, "_dram_addr"}, dram_addr, 0);
    check({name, "_sram_cs"}, {31'd0, sram_cs}, 0);
    check({name, "_sram_we"}, {31'd0, sram_we}, 0);
  endtask

  initial begin
    rst = 1; cfg_start = 0; cfg_end = 0; cfg_sram_base = 0; cfg_dir = 0; cfg_go = 0; irq_clr = 0;
    model_en = 1; spur_rdy = 0; spur_sd = 0; spur_rdata = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    for (int i = 0; i < 4; i++) dram_mem[32'h100 + 4*i] = 32'hA0 + i;
    dram_mem[32'h400] = 32'h11; dram_mem[32'h404] = 32'h22; dram_mem[32'h500] = 32'h55;
    @(posedge clk); #1 pre_we = 1; pre_addr = 12'h10; pre_data = 32'hDEAD0001;
    @(posedge clk); #1 pre_addr = 12'h11; pre_data = 32'hDEAD0002;
    @(posedge clk); #1 pre_we = 0;
    reset_outputs("reset");
    @(posedge clk); #1 rst = 0;

    // DRAM -> SRAM, four words
    for (int i = 0; i < 4; i++) begin
      exp_dram.push_back('{32'h100 + 4*i, 1'b1, 32'h0, 1'b0});
      exp_sram.push_back('{12'h20 + 12'(i), 32'hA0 + i});
    end
    exp_done.push_back(1'b0);
    go(32'h100, 32'h10C, 12'h20, 1'b0);
    check("busy_after_go", {31'd0, busy}, 1);
    wait_done("d2s", 200);
    check("d2s_busy_low", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++) check("d2s_sram_mem", sram_mem[12'h20 + 12'(i)], 32'hA0 + i);
    drain_check("d2s");
    clear_irq();

    // SRAM -> DRAM, two words
    exp_dram.push_back('{32'h200, 1'b0, 32'hDEAD0001, 1'b1});
    exp_dram.push_back('{32'h204, 1'b0, 32'hDEAD0002, 1'b1});
    exp_done.push_back(1'b0);
    go(32'h200, 32'h204, 12'h10, 1'b1);
    wait_done("s2d", 200);
    check("s2d_mem0", dram_mem[32'h200], 32'hDEAD0001);
    check("s2d_mem1", dram_mem[32'h204], 32'hDEAD0002);
    drain_check("s2d");
    clear_irq();

    // end < start: immediate error completion
    exp_done.push_back(1'b1);
    go(32'h300, 32'h2FC, 12'h0, 1'b0);
    check("range_done_next_cycle", {31'd0, done}, 1);
    check("range_err_next_cycle", {31'd0, err}, 1);
    check("range_busy", {31'd0, busy}, 0);
    drain_check("range");
    clear_irq();

    // Re-go and spurious store ack during a read, with SRAM address wrap
    exp_dram.push_back('{32'h400, 1'b1, 32'h0, 1'b0});
    exp_dram.push_back('{32'h404, 1'b1, 32'h0, 1'b0});
    exp_sram.push_back('{12'hFFF, 32'h11});
    exp_sram.push_back('{12'h000, 32'h22});
    exp_done.push_back(1'b0);
    go(32'h400, 32'h404, 12'hFFF, 1'b0);
    wait_access(50);
    @(posedge clk); #1;
    spur_sd = 1; cfg_go = 1; cfg_dir = 1; cfg_start = 32'h800; cfg_end = 32'h8FC;
    @(posedge clk); #1;
    spur_sd = 0; cfg_go = 0;
    wait_done("ignore", 200);
    drain_check("ignore");
    clear_irq();

    // Reset while waiting in DWAIT, then a late read ack
    model_en = 0;
    exp_dram.push_back('{32'h500, 1'b1, 32'h0, 1'b0});
    go(32'h500, 32'h500, 12'h30, 1'b0);
    wait_access(50);
    @(posedge clk); #1;
    rst = 1; #1;
    reset_outputs("abort");
    @(posedge clk); #1 rst = 0;
    spur_rdata = 32'h5555_5555; spur_rdy = 1;
    @(posedge clk); #1 spur_rdy = 0;
    repeat (5) @(posedge clk); #1;
    reset_outputs("abort_late_ack");
    drain_check("abort");

`ifdef DMA_TIMEOUT_EN
    begin
      int n = 0;
      exp_dram.push_back('{32'h600, 1'b1, 32'h0, 1'b0});
      exp_done.push_back(1'b1);
      go(32'h600, 32'h604, 12'h40, 1'b0);
      wait_access(50);
      while (!done && n < 50) begin @(negedge clk); n++; end
      check("timeout_latency", n, 32'd9);
      check("timeout_err", {31'd0, err}, 1);
      drain_check("timeout");
      clear_irq();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=0", 1);
    $fatal(1);
  end

endmodule

// File: doc/dma_dram_engine.md
Name: dma_dram_engine

Overview:
- DMA sequencer that sits directly upstream of the DRAM wrapper and drives its request interface: access strobe, write flag, size, address and write data.
- Moves a word-aligned block between DRAM and a local single-port SRAM.
- Direction 0: DRAM to SRAM. Direction 1: SRAM to DRAM.
- One DRAM word is in flight at a time. Completion is signalled to the CPU by a sticky done/irq flag.

Parameters:
- ADDR_W, 32, DRAM byte-address width
- SRAM_AW, 12, SRAM word-address width
- MAX_WORDS_W, 16, width of the internal word counter
- TIMEOUT_CYC, 64, cycles to wait for a DRAM ack (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  ADDR_W  first DRAM byte address (bits [1:0] ignored)
- cfg_end  in  ADDR_W  last DRAM byte address, inclusive
- cfg_sram_base  in  SRAM_AW  first SRAM word address
- cfg_dir  in  1  0 = DRAM->SRAM, 1 = SRAM->DRAM
- cfg_go  in  1  1-cycle start pulse; ignored unless IDLE
- irq_clr  in  1  clears done/err
- busy  out  1  high from go accepted until DONE
- done  out  1  sticky completion flag (irq)
- err  out  1  sticky error flag
- dram_access  out  1  1-cycle request strobe to the wrapper
- dram_w  out  1  active low: 0 = write, 1 = read
- dram_size  out  2  always 2'b10 (word)
- dram_addr  out  ADDR_W  request address
- dram_wdata  out  32  write data
- dram_rdata  in  32  read data, valid with dram_data_ready
- dram_data_ready  in  1  read completion pulse
- dram_store_done  in  1  write completion pulse
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_addr  out  SRAM_AW  SRAM word address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, 1-cycle latency

Behaviour:
- Reset: state IDLE. All outputs 0 except dram_w=1 and dram_size=2'b10. Counters and registers cleared.
- Config is latched on the cfg_go cycle. Word count N = (end[ADDR_W-1:2] - start[ADDR_W-1:2]) + 1.
- If end < start: no DRAM access, err=1 and done=1 the next cycle.
- States:
  - IDLE: on cfg_go, latch config and go to SRD if dir=1, else DREQ.
  - SRD: assert sram_cs, we=0 at the current SRAM address for 1 cycle, then go to SCAP.
  - SCAP: capture sram_rdata into the write-data register, then go to DREQ.
  - DREQ: dram_access=1 for exactly 1 cycle, with dram_w=~dir and the current address, then go to DWAIT.
  - DWAIT: hold dram_addr, dram_w and dram_wdata stable.
    - Read: on dram_data_ready, capture dram_rdata and go to SWR.
    - Write: on dram_store_done, go to NEXT.
    - Acks of the wrong type are ignored.
  - SWR: sram_cs=1, we=1, wdata = captured word, 1 cycle, then go to NEXT.
  - NEXT: DRAM addr += 4, SRAM addr += 1 (wraps modulo 2^SRAM_AW), remaining -= 1. If remaining reaches 0, go to DONE; else go to SRD or DREQ.
  - DONE: set done, drop busy, go to IDLE.
- Latency per word: read = 3 + DRAM latency cycles; write = 4 + DRAM latency cycles.
- done and err hold until irq_clr. If irq_clr and a new completion occur in the same cycle, the completion wins.
- cfg_go while busy is ignored. Config inputs may change freely after go.
- An ack arriving outside DWAIT is ignored.
- Address increments wrap modulo 2^ADDR_W with no error.
- rst mid-transfer aborts immediately: outputs return to reset values and any DRAM ack arriving later is ignored.

Optional Feature:
- Macro: DMA_TIMEOUT_EN.
- When defined: a counter runs in DWAIT. If TIMEOUT_CYC cycles pass without an ack, the engine aborts to DONE with err=1 and done=1; remaining words are not transferred.
- When undefined: no counter is built, and DWAIT waits indefinitely.

Decomposition:
- Package dma_pkg holds:
  - the state enum (IDLE, SRD, SCAP, DREQ, DWAIT, SWR, NEXT, DONE)
  - constants DIR_D2S=0, DIR_S2D=1, SIZE_WORD=2'b10, DRAM_W_READ=1, DRAM_W_WRITE=0
- One natural sub-module: dma_addr_gen, containing the DRAM/SRAM address registers, remaining-count register and the last-word compare.
- The FSM stays in the top module.

Test Plan:
- DRAM->SRAM, start=0x100, end=0x10C, base=0x20; DRAM model returns 0xA0..0xA3 with 3-cycle latency -> SRAM 0x20..0x23 = A0..A3; exactly 4 dram_access pulses with dram_w=1; done=1, err=0.
- SRAM->DRAM, SRAM 0x10..0x11 = 0xDEAD0001/0xDEAD0002, start=end-4=0x200 -> writes to 0x200 and 0x204 with dram_w=0 and those data; 2 store_done acks; then done.
- start=0x300, end=0x2FC -> no dram_access; err=1 and done=1 one cycle after go; irq_clr clears both.
- cfg_go pulsed again mid-transfer, and a spurious dram_store_done during a read -> both ignored; transfer completes unchanged.
- rst asserted in DWAIT, then a late dram_data_ready -> all outputs at reset values; no SRAM write.
- With DMA_TIMEOUT_EN and TIMEOUT_CYC=8, the DRAM model never acks -> err=1 and done=1 exactly 8 cycles after DWAIT entry.
